// File: rtl/led_pwm_bank.sv
// led_pwm_bank: a bank of LED drivers sharing one free-running prescale counter.
// Each channel is independently off, on, blinking (counter MSB) or PWM-dimmed.
// PWM duty values pass through a per-channel shadow register that only reloads
// at the start of a PWM period, so a duty change never produces a runt pulse.
//
// Handshake: there is none. MODE is sampled every cycle. DUTY is sampled only
// in the cycle where the low counter field is all-ones and EN is high.
module led_pwm_bank #(
    parameter int WIDTH      = 22,
    parameter int CHANNELS   = 4,
    parameter int DUTY_WIDTH = 8
) (
    input  logic                           CLK,
    input  logic                           RESETN,
    input  logic                           EN,
    input  logic [2*CHANNELS-1:0]          MODE,
    input  logic [DUTY_WIDTH*CHANNELS-1:0] DUTY,
    output logic [CHANNELS-1:0]            LED,
    output logic [WIDTH-1:0]               COUNT,
    output logic                           TICK
);

    localparam logic [1:0] MODE_OFF   = 2'b00;
    localparam logic [1:0] MODE_ON    = 2'b01;
    localparam logic [1:0] MODE_BLINK = 2'b10;

    localparam logic [WIDTH-1:0] COUNT_ONE = {{(WIDTH-1){1'b0}}, 1'b1};

    logic [WIDTH-1:0]                     count_q, count_d;
    logic [CHANNELS-1:0][DUTY_WIDTH-1:0]  sh_q, sh_d;
    logic [CHANNELS-1:0]                  led_q, led_d;
    logic                                 tick_q, tick_d;

    logic [DUTY_WIDTH-1:0]                low_field;
    logic                                 low_wrap;

    // PWM phase is the low field of the shared counter; its wrap marks a period start
    always_comb begin
        low_field = count_q[DUTY_WIDTH-1:0];
        low_wrap  = EN && (low_field == {DUTY_WIDTH{1'b1}});
    end

    // Next-state for counter, wrap pulse, duty shadows and LED drive
    always_comb begin
        count_d = EN ? (count_q + COUNT_ONE) : count_q;
        tick_d  = EN && (count_q == {WIDTH{1'b1}});
        sh_d    = sh_q;
        led_d   = '0;
        for (int c = 0; c < CHANNELS; c++) begin
            if (low_wrap) begin
                sh_d[c] = DUTY[c*DUTY_WIDTH +: DUTY_WIDTH];
            end
            // LED uses the shadow as it stands this cycle, so a freshly
            // loaded duty first shows on the LED sample for L = 0.
            case (MODE[2*c +: 2])
                MODE_OFF:   led_d[c] = 1'b0;
                MODE_ON:    led_d[c] = 1'b1;
                MODE_BLINK: led_d[c] = count_q[WIDTH-1];
                default:    led_d[c] = (low_field < sh_q[c]);
            endcase
        end
    end

    // State registers with asynchronous active-low clear
    always_ff @(posedge CLK or negedge RESETN) begin
        if (!RESETN) begin
            count_q <= '0;
            sh_q    <= '0;
            led_q   <= '0;
            tick_q  <= 1'b0;
        end else begin
            count_q <= count_d;
            sh_q    <= sh_d;
            led_q   <= led_d;
            tick_q  <= tick_d;
        end
    end

    assign LED   = led_q;
    assign COUNT = count_q;
    assign TICK  = tick_q;

endmodule

// File: tb/tb_led_pwm_bank.sv
// Bench for led_pwm_bank at WIDTH=8, DUTY_WIDTH=4, CHANNELS=2.
// A behavioural model predicts COUNT/LED/TICK every cycle into a scoreboard
// queue; directed sequences and a vector table cover the documented corners.
module tb_led_pwm_bank;

    localparam int W  = 8;
    localparam int C  = 2;
    localparam int DW = 4;

    typedef logic [10:0] exp_t;  // {led[1:0], tick, count[7:0]}

    typedef struct {
        logic [1:0] mode;
        logic [3:0] duty;
        int         exp_hi;
    } pwm_vec_t;

    // ---------------- clock / reset / DUT ----------------
    logic         clk   = 1'b0;
    logic         rst_n = 1'b0;
    logic         en    = 1'b0;
    logic [3:0]   mode  = '0;
    logic [7:0]   duty  = '0;
    logic [1:0]   led;
    logic [7:0]   count;
    logic         tick;

    always #5 clk = ~clk;

    led_pwm_bank #(.WIDTH(W), .CHANNELS(C), .DUTY_WIDTH(DW)) dut (
        .CLK    (clk),
        .RESETN (rst_n),
        .EN     (en),
        .MODE   (mode),
        .DUTY   (duty),
        .LED    (led),
        .COUNT  (count),
        .TICK   (tick)
    );

    int   n_checks = 0;
    int   n_fail   = 0;
    logic chk_on   = 1'b0;
    exp_t exp_q[$];
    exp_t sb_e;

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    int         m_count;
    logic [3:0] m_sh [C];

    function automatic logic led_ref(logic [1:0] md, int cnt, logic [3:0] sh);
        case (md)
            2'd0:    return 1'b0;
            2'd1:    return 1'b1;
            2'd2:    return cnt >= 128;          // upper half of the blink period
            default: return (cnt % 16) < int'(sh); // lit for the first sh cycles
        endcase
    endfunction

    always @(posedge clk or negedge rst_n) begin : model
        if (!rst_n) begin
            m_count <= 0;
            for (int c = 0; c < C; c++) m_sh[c] <= '0;
            exp_q.delete();
            exp_q.push_back('0);
        end else begin
            exp_q.push_back({led_ref(mode[3:2], m_count, m_sh[1]),
                             led_ref(mode[1:0], m_count, m_sh[0]),
                             logic'(en && m_count == 255),
                             8'((m_count + int'(en)) % 256)});
            if (en && (m_count % 16) == 15)
                for (int c = 0; c < C; c++) m_sh[c] <= duty[c*4 +: 4];
            m_count <= (m_count + int'(en)) % 256;
        end
    end

    // ---------------- scoreboard ----------------
    always @(negedge clk) begin
        if (chk_on) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL sb_empty: got no prediction expected one (t=%0t)", $time);
            end else begin
                sb_e = exp_q.pop_front();
                check("sb_count", count, sb_e[7:0]);
                check("sb_tick",  tick,  sb_e[8]);
                check("sb_led",   led,   sb_e[10:9]);
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic step(int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic set_ch(int c, logic [1:0] m, logic [3:0] d);
        mode[2*c +: 2] = m;
        duty[4*c +: 4] = d;
    endtask

    task automatic wait_low(int val, string name);
        int k = 0;
        while (int'(count[3:0]) != val && k < 300) begin
            step(1);
            k++;
        end
        if (k >= 300) check({name, "_timeout"}, count[3:0], val);
    endtask

    task automatic wait_count(int val, string name);
        int k = 0;
        while (int'(count) != val && k < 300) begin
            step(1);
            k++;
        end
        if (k >= 300) check({name, "_timeout"}, count, val);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got no finish expected finish by 2000000");
        $fatal(1, "watchdog");
    end

    // ---------------- test sequence ----------------
    initial begin
        pwm_vec_t vecs[6];
        int       hi, hi2, ticks, prev;

        vecs[0] = '{2'd3, 4'd4,  4};
        vecs[1] = '{2'd3, 4'd0,  0};
        vecs[2] = '{2'd3, 4'd15, 15};
        vecs[3] = '{2'd3, 4'd9,  9};
        vecs[4] = '{2'd1, 4'd3,  16};
        vecs[5] = '{2'd0, 4'd12, 0};

        // Reset / idle
        rst_n = 1'b0;
        en    = 1'b1;
        @(posedge clk);
        #1;
        chk_on = 1'b1;
        step(4);
        check("reset_count", count, 0);
        check("reset_led",   led,   0);
        check("reset_tick",  tick,  0);
        rst_n = 1'b1;
        step(10);
        check("count_after_release", count, 10);

        // Wrap and TICK over 512 cycles
        ticks = 0;
        prev  = -1;
        for (int i = 0; i < 512; i++) begin
            step(1);
            if (tick) begin
                ticks++;
                check("tick_at_zero", count, 0);
                if (prev >= 0) check("tick_spacing", i - prev, 256);
                prev = i;
            end
        end
        check("tick_total", ticks, 2);

        // Blink on channel 0
        set_ch(0, 2'd2, 4'd0);
        wait_count(128, "blink_rise");
        check("blink_before_rise", led[0], 0);
        step(1);
        check("blink_after_rise", led[0], 1);
        wait_count(0, "blink_fall");
        check("blink_before_fall", led[0], 1);
        step(1);
        check("blink_after_fall", led[0], 0);
        hi = 0;
        for (int i = 0; i < 256; i++) begin
            step(1);
            hi += int'(led[0]);
        end
        check("blink_high_cycles", hi, 128);
        set_ch(0, 2'd0, 4'd0);

        // Per-mode / per-duty high counts on channel 1 over one period
        for (int v = 0; v < 6; v++) begin
            set_ch(1, vecs[v].mode, vecs[v].duty);
            wait_low(15, "pwm_align");
            step(1);
            hi = 0;
            for (int i = 0; i < 16; i++) begin
                step(1);
                hi += int'(led[1]);
            end
            check($sformatf("vec%0d_high_cycles", v), hi, vecs[v].exp_hi);
        end

        // Glitch-free duty change 4 -> 12 at L=6
        set_ch(1, 2'd3, 4'd4);
        wait_low(15, "glitch_align");
        step(2);
        hi  = 0;
        hi2 = 0;
        for (int i = 0; i < 32; i++) begin
            if (i < 16) hi += int'(led[1]);
            else        hi2 += int'(led[1]);
            if (i < 16 && count[3:0] == 4'd6) duty[7:4] = 4'd12;
            step(1);
        end
        check("glitch_old_period", hi, 4);
        check("glitch_new_period", hi2, 12);

        // EN freeze at COUNT=37 (ch0 on, ch1 PWM duty 12)
        set_ch(0, 2'd1, 4'd0);
        wait_count(37, "freeze_align");
        en = 1'b0;
        for (int i = 0; i < 20; i++) begin
            step(1);
            check("freeze_count", count, 37);
            check("freeze_tick",  tick,  0);
            check("freeze_led",   led,   2'b11);
        end
        set_ch(0, 2'd0, 4'd0);
        step(1);
        check("freeze_mode_change", led, 2'b10);
        set_ch(0, 2'd1, 4'd0);
        step(1);

        // Asynchronous reset between edges
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check("async_count", count, 0);
        check("async_led",   led,   0);
        check("async_tick",  tick,  0);
        step(2);
        rst_n = 1'b1;
        en    = 1'b1;

        // EN low in the L=15 cycle defers the shadow load
        set_ch(1, 2'd3, 4'd12);
        wait_low(15, "enlow_align");
        en = 1'b0;
        duty[7:4] = 4'd5;
        step(3);
        check("enlow_count_held", count[3:0], 15);
        check("enlow_no_tick", tick, 0);
        en = 1'b1;
        step(2);
        hi = 0;
        for (int i = 0; i < 16; i++) begin
            hi += int'(led[1]);
            step(1);
        end
        check("enlow_deferred_duty", hi, 5);

        // Randomised traffic, checked by the model
        for (int i = 0; i < 3000; i++) begin
            en = ($urandom_range(0, 7) != 0);
            if ($urandom_range(0, 15) == 0) mode = 4'($urandom);
            if ($urandom_range(0, 7) == 0)  duty = 8'($urandom);
            rst_n = ($urandom_range(0, 499) != 0);
            step(1);
        end
        rst_n = 1'b1;
        step(2);

        chk_on = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
